// File: rtl/restoring_div8_pkg.sv
// Shared constants and FSM state type for the restoring divider.
package div_pkg;

  localparam int unsigned Width = 8;
  localparam int unsigned CntW  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/restoring_div8_if.sv
// Operand/result handshake bundle for restoring_div8.
interface restoring_div8_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz
  );

endinterface

// File: rtl/restoring_div8_div_step.sv
// One restoring-division step: shift {rem,q}, trial subtract via carry-select adder, restore on
// borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  localparam int unsigned N      = WIDTH + 1;
  localparam int unsigned Blk    = 4;
  localparam int unsigned NumBlk = (N + Blk - 1) / Blk;

  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [N-1:0]    w_sum;
  logic [NumBlk:0] w_blk_c;
  logic            w_c0;
  logic            w_c1;
  logic            w_s0;
  logic            w_s1;
  logic            w_no_borrow;
  logic            w_unused;

  assign w_a = {i_rem, i_q[WIDTH-1]};
  assign w_b = ~{1'b0, i_divisor};

  // Each block ripples both carry-in hypotheses; the incoming block carry picks one.
  always_comb begin
    w_sum      = '0;
    w_blk_c    = '0;
    w_blk_c[0] = 1'b1;
    w_c0       = 1'b0;
    w_c1       = 1'b1;
    w_s0       = 1'b0;
    w_s1       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i % Blk == 0) begin
        w_c0 = 1'b0;
        w_c1 = 1'b1;
      end
      w_s0     = w_a[i] ^ w_b[i] ^ w_c0;
      w_s1     = w_a[i] ^ w_b[i] ^ w_c1;
      w_c0     = (w_a[i] & w_b[i]) | (w_c0 & (w_a[i] ^ w_b[i]));
      w_c1     = (w_a[i] & w_b[i]) | (w_c1 & (w_a[i] ^ w_b[i]));
      w_sum[i] = w_blk_c[i / Blk] ? w_s1 : w_s0;
      if ((i % Blk == Blk - 1) || (i == N - 1)) begin
        w_blk_c[i / Blk + 1] = w_blk_c[i / Blk] ? w_c1 : w_c0;
      end
    end
  end

  assign w_no_borrow = w_blk_c[NumBlk];
  assign w_unused    = w_sum[WIDTH];

  assign o_rem = w_no_borrow ? w_sum[WIDTH-1:0] : w_a[WIDTH-1:0];
  assign o_q   = {i_q[WIDTH-2:0], w_no_borrow};

endmodule

// File: rtl/restoring_div8.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_BY_ZERO_CHK_EN to short-circuit a zero divisor and raise dbz.
module restoring_div8
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input logic              clk,
  input logic              rst_n,
  restoring_div8_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] w_dvs_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic             r_dbz;
  logic             w_dbz_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_q   <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_dvs <= w_dvs_nxt;
      r_cnt <= w_cnt_nxt;
      r_dbz <= w_dbz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_dvs_nxt   = r_dvs;
    w_cnt_nxt   = r_cnt;
    w_dbz_nxt   = r_dbz;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_dvs_nxt   = bus.divisor;
          w_rem_nxt   = '0;
          w_q_nxt     = bus.dividend;
          w_cnt_nxt   = '0;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = StRun;
`ifdef DIV_BY_ZERO_CHK_EN
          // Result is known up front; RUN is passed through for a single cycle.
          if (bus.divisor == '0) begin
            w_rem_nxt = bus.dividend;
            w_q_nxt   = '1;
            w_dbz_nxt = 1'b1;
          end
`endif
        end
      end
      StRun: begin
        w_rem_nxt = w_step_rem;
        w_q_nxt   = w_step_q;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntW'(WIDTH - 1)) begin
          w_state_nxt = StDone;
        end
`ifdef DIV_BY_ZERO_CHK_EN
        if (r_dbz) begin
          w_rem_nxt   = r_rem;
          w_q_nxt     = r_q;
          w_cnt_nxt   = '0;
          w_state_nxt = StDone;
        end
`endif
      end
      StDone: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.quotient  = r_q;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;

endmodule

// File: tb/tb_restoring_div8.sv
// Self-checking bench for restoring_div8: directed cases plus random operations against an
// arithmetic model of the handshake and the quotient/remainder.
module tb_restoring_div8;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  restoring_div8_if #(.WIDTH(8)) bus ();

  restoring_div8 #(
    .WIDTH (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is outstanding from acceptance until the output handshake; the
  // result appears m_lat cycles after acceptance.
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  int         m_lat  = 8;
  logic [7:0] m_q    = '0;
  logic [7:0] m_r    = '0;
  logic       m_dbz  = 1'b0;

  function automatic int model_lat(input logic [7:0] b);
`ifdef DIV_BY_ZERO_CHK_EN
    return (b == 8'd0) ? 1 : 8;
`else
    return (b == 8'd0) ? 8 : 8;
`endif
  endfunction

  function automatic logic model_dbz(input logic [7:0] b);
`ifdef DIV_BY_ZERO_CHK_EN
    return (b == 8'd0);
`else
    return (b == 8'd0) ? 1'b0 : 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_lat  = model_lat(bus.divisor);
        m_dbz  = model_dbz(bus.divisor);
        m_q    = (bus.divisor == 8'd0) ? 8'hFF : bus.dividend / bus.divisor;
        m_r    = (bus.divisor == 8'd0) ? bus.dividend : bus.dividend % bus.divisor;
      end
    end else if (m_age >= m_lat && bus.out_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_quotient", 32'(bus.quotient), 32'd0);
      check("reset_remainder", 32'(bus.remainder), 32'd0);
      check("reset_dbz", 32'(bus.dbz), 32'd0);
    end else if (m_busy) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      check("busy_out_valid", 32'(bus.out_valid), 32'(m_age >= m_lat));
      if (m_age >= m_lat) begin
        check("quotient", 32'(bus.quotient), 32'(m_q));
        check("remainder", 32'(bus.remainder), 32'(m_r));
        check("dbz", 32'(bus.dbz), 32'(m_dbz));
      end
    end else begin
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_quotient_hold", 32'(bus.quotient), 32'(m_q));
      check("idle_remainder_hold", 32'(bus.remainder), 32'(m_r));
    end
  end

  // Issue one operation, scramble the operand inputs while it runs, hold out_ready low for
  // 'hold' cycles in DONE, then complete the handshake.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       input bit wiggle, output logic [7:0] q, output logic [7:0] r,
                       output logic d, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = wiggle;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.dividend = 8'($urandom_range(0, 255));
      bus.divisor  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("result_arrived", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(lat), 32'(model_lat(b)));
    q = bus.quotient;
    r = bus.remainder;
    d = bus.dbz;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
  endtask

  logic [7:0] q;
  logic [7:0] r;
  logic       d;
  int         lat;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    do_op(8'd200, 8'd7, 0, 1'b0, q, r, d, lat);
    check("200/7 quotient", 32'(q), 32'd28);
    check("200/7 remainder", 32'(r), 32'd4);
    check("200/7 dbz", 32'(d), 32'd0);
    check("200/7 latency", 32'(lat), 32'd8);

    do_op(8'd255, 8'd1, 0, 1'b0, q, r, d, lat);
    check("255/1 quotient", 32'(q), 32'd255);
    check("255/1 remainder", 32'(r), 32'd0);

    do_op(8'd5, 8'd9, 1, 1'b0, q, r, d, lat);
    check("5/9 quotient", 32'(q), 32'd0);
    check("5/9 remainder", 32'(r), 32'd5);

    do_op(8'd100, 8'd0, 0, 1'b0, q, r, d, lat);
    check("100/0 quotient", 32'(q), 32'hFF);
    check("100/0 remainder", 32'(r), 32'd100);
`ifdef DIV_BY_ZERO_CHK_EN
    check("100/0 dbz", 32'(d), 32'd1);
    check("100/0 latency", 32'(lat), 32'd1);
`else
    check("100/0 dbz", 32'(d), 32'd0);
    check("100/0 latency", 32'(lat), 32'd8);
`endif

    // Stall in DONE; the per-cycle compare holds outputs and in_ready=0 throughout.
    do_op(8'd123, 8'd10, 5, 1'b0, q, r, d, lat);
    check("123/10 quotient", 32'(q), 32'd12);
    check("123/10 remainder", 32'(r), 32'd3);

    // Reset pulse after four RUN steps.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_reset_quotient", 32'(bus.quotient), 32'd0);
    check("midrun_reset_remainder", 32'(bus.remainder), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("after_abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_abort_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(8'd64, 8'd8, 0, 1'b0, q, r, d, lat);
    check("64/8 quotient", 32'(q), 32'd8);
    check("64/8 remainder", 32'(r), 32'd0);

    // in_valid held high with scrambled operands during RUN.
    do_op(8'd200, 8'd7, 2, 1'b1, q, r, d, lat);
    check("200/7 scrambled quotient", 32'(q), 32'd28);
    check("200/7 scrambled remainder", 32'(r), 32'd4);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      bit         w;
      a = 8'($urandom_range(0, 255));
      b = (k % 8 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      w = (k % 2 == 1);
      do_op(a, b, int'($urandom_range(0, 3)), w, q, r, d, lat);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/restoring_div8.md
RESTORING_DIV8 -- requirements
Module: restoring_div8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; only 8 is verified.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operands present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port divisor  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a rising edge with in_valid&&in_ready: latch divisor, clear partial remainder, load the shift register with dividend, clear the iteration counter, go to RUN.
REQ-016 SHALL perform one restoring step per RUN cycle: shift {rem,q} left by 1, trial = rem - divisor at WIDTH+1 bits, keep the difference and set the q LSB to 1 if the borrow is 0, else restore and set it to 0.
REQ-017 SHALL leave RUN after exactly WIDTH steps (3-bit counter reaching 7 wraps to DONE), so out_valid rises WIDTH cycles after the acceptance edge.
REQ-018 SHALL hold quotient, remainder and dbz stable in DONE until out_valid&&out_ready, then go to IDLE.
REQ-019 SHALL NOT accept a new operation in the same cycle as a DONE handshake; in_ready rises the cycle after (no back-to-back overlap).
REQ-020 SHALL ignore in_valid, dividend and divisor changes during RUN and DONE.
REQ-021 SHALL hold quotient and remainder at their last values in IDLE; they are only meaningful while out_valid=1.

Reset
REQ-022 SHALL on rst_n low immediately enter IDLE and clear the counter, quotient, remainder and dbz to 0, with out_valid=0 and in_ready=1 after release.
REQ-023 SHALL abort an in-flight operation on reset mid-RUN or mid-DONE with no result produced.

Configuration
REQ-024 SHALL support macro DIV_BY_ZERO_CHK_EN.
REQ-025 SHALL, when DIV_BY_ZERO_CHK_EN is defined and divisor==0 at acceptance, skip RUN, enter DONE on the next edge and present quotient=all-ones, remainder=dividend, dbz=1.
REQ-026 SHALL, when DIV_BY_ZERO_CHK_EN is undefined, run a zero divisor through the normal WIDTH-cycle algorithm (giving quotient=all-ones, remainder=dividend) with dbz tied to 0.

Structure
REQ-027 SHALL place the WIDTH default, the state enum (IDLE/RUN/DONE) and the counter width constant in shared package div_pkg.
REQ-028 SHALL isolate the combinational trial subtract/restore in one sub-module div_step (inputs rem, q, divisor; outputs next rem, q), built on the team's carry-select adder cells with the divisor inverted and carry-in 1.

Verification
REQ-029 SHALL check that 200/7 gives quotient=28, remainder=4, dbz=0, with out_valid exactly 8 cycles after acceptance.
REQ-030 SHALL check that 255/1 gives quotient=255, remainder=0, and that 5/9 gives quotient=0, remainder=5.
REQ-031 SHALL check that 100/0 gives quotient=0xFF, remainder=100, with the macro on: dbz=1 and latency 1; with the macro off: dbz=0 and latency 8.
REQ-032 SHALL check that holding out_ready=0 for 5 cycles in DONE keeps outputs stable and in_ready=0, and in_ready=1 one cycle after the handshake.
REQ-033 SHALL check that rst_n pulsed low at RUN step 4 gives out_valid=0, in_ready=1 and outputs 0, and that the next 64/8 gives quotient=8, remainder=0.
REQ-034 SHALL check that operand changes on dividend/divisor while in RUN do not affect the 200/7 result.
